// File: rtl/control_mag_pwm.sv
// Magnetron controller with a clocked IDLE/RUN/PAUSE state machine and
// slot-based duty cycling. Each frame is SLOTS slots of SLOT_CYCLES clocks;
// the magnetron is driven for the first pwr_q slots of every frame.
// The door interlock gates mag_on combinationally, so an opening door
// removes drive within the same cycle. The state moves to PAUSE at the next edge.
//
// Key inputs are active-low levels. A key acts once, on its falling edge,
// detected against a registered copy of the key. A key held low fires only once.
module control_mag_pwm #(
    parameter int SLOTS       = 10,
    parameter int SLOT_CYCLES = 100,
    parameter int PWR_W       = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             startn,
    input  logic             stopn,
    input  logic             clearn,
    input  logic             door_closed,
    input  logic             timer_done,
    input  logic [PWR_W-1:0] power_level,
    output logic             mag_on,
    output logic             running,
    output logic             paused
);

    localparam int CYC_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(SLOT_CYCLES - 1);
    localparam logic [PWR_W-1:0] SLOT_LAST = PWR_W'(SLOTS - 1);
    localparam logic [PWR_W-1:0] SLOTS_P   = PWR_W'(SLOTS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic             startn_q;
    logic             stopn_q;
    logic             clearn_q;
    logic             start_ev;
    logic             stop_ev;
    logic             clear_ev;
    logic             enter_run;
    logic [PWR_W-1:0] pwr_clamped;
    logic [PWR_W-1:0] pwr_q;
    logic [PWR_W-1:0] slot_idx;
    logic [CYC_W-1:0] cyc_cnt;

    assign start_ev    = ~startn & startn_q;
    assign stop_ev     = ~stopn  & stopn_q;
    assign clear_ev    = ~clearn & clearn_q;
    assign pwr_clamped = (power_level > SLOTS_P) ? SLOTS_P : power_level;
    assign enter_run   = (state_nx == RUN) && (state != RUN);

    // Key history: the previous level of each key, reset released (high).
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            startn_q <= 1'b1;
            stopn_q  <= 1'b1;
            clearn_q <= 1'b1;
        end else begin
            startn_q <= startn;
            stopn_q  <= stopn;
            clearn_q <= clearn;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode in priority order: clear, timer, door, stop, start.
    always_comb begin
        state_nx = state;
        if (clear_ev) begin
            state_nx = IDLE;
        end else if (timer_done && (state == RUN)) begin
            state_nx = IDLE;
        end else if (!door_closed && (state == RUN)) begin
            state_nx = PAUSE;
        end else if (stop_ev) begin
            state_nx = (state == RUN) ? PAUSE : IDLE;
        end else if (start_ev && door_closed && !timer_done && (state != RUN)) begin
            state_nx = RUN;
        end
    end

    // Slot/cycle counters and frame power. Every RUN entry starts a fresh
    // frame; the power level is only sampled at frame starts.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            slot_idx <= '0;
            cyc_cnt  <= '0;
            pwr_q    <= '0;
        end else if (enter_run) begin
            slot_idx <= '0;
            cyc_cnt  <= '0;
            pwr_q    <= pwr_clamped;
        end else if (state == RUN) begin
            if (cyc_cnt == CYC_LAST) begin
                cyc_cnt <= '0;
                if (slot_idx == SLOT_LAST) begin
                    slot_idx <= '0;
                    pwr_q    <= pwr_clamped;
                end else begin
                    slot_idx <= slot_idx + 1'b1;
                end
            end else begin
                cyc_cnt <= cyc_cnt + 1'b1;
            end
        end
    end

    // Outputs decoded from registers; the door gates drive without latency.
    always_comb begin
        running = (state == RUN);
        paused  = (state == PAUSE);
        mag_on  = (state == RUN) && (slot_idx < pwr_q) && door_closed;
    end

endmodule

// File: tb/tb_control_mag_pwm.sv
// Bench for control_mag_pwm (SLOTS=4, SLOT_CYCLES=2, PWR_W=3).
// The reference model tracks the mode and the elapsed RUN time since entry.
// The expected drive comes from that time by frame/slot arithmetic.
module tb_control_mag_pwm;

    localparam int SLOTS       = 4;
    localparam int SLOT_CYCLES = 2;
    localparam int PWR_W       = 3;
    localparam int FRAME       = SLOTS * SLOT_CYCLES;
    localparam int M_IDLE      = 0;
    localparam int M_RUN       = 1;
    localparam int M_PAUSE     = 2;

    // ---------------- clock / reset ----------------
    logic             clk = 1'b0;
    logic             resetn;
    logic             startn;
    logic             stopn;
    logic             clearn;
    logic             door_closed;
    logic             timer_done;
    logic [PWR_W-1:0] power_level;
    logic             mag_on;
    logic             running;
    logic             paused;

    always #5 clk = ~clk;

    control_mag_pwm #(
        .SLOTS      (SLOTS),
        .SLOT_CYCLES(SLOT_CYCLES),
        .PWR_W      (PWR_W)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .startn     (startn),
        .stopn      (stopn),
        .clearn     (clearn),
        .door_closed(door_closed),
        .timer_done (timer_done),
        .power_level(power_level),
        .mag_on     (mag_on),
        .running    (running),
        .paused     (paused)
    );

    // ---------------- scoreboard ----------------
    int   n_cmp = 0;
    int   n_err = 0;
    logic exp_q[$];
    logic obs_mag;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int   m_mode;
    int   m_t;
    int   m_fpwr;
    logic m_pstart;
    logic m_pstop;
    logic m_pclear;

    function automatic int clamp_pwr(input int p);
        return (p > SLOTS) ? SLOTS : p;
    endfunction

    function automatic logic exp_mag();
        return (m_mode == M_RUN) && door_closed &&
               (((m_t % FRAME) / SLOT_CYCLES) < m_fpwr);
    endfunction

    task automatic model_reset();
        m_mode   = M_IDLE;
        m_t      = 0;
        m_fpwr   = 0;
        m_pstart = 1'b1;
        m_pstop  = 1'b1;
        m_pclear = 1'b1;
    endtask

    task automatic model_edge();
        logic s_ev;
        logic p_ev;
        logic c_ev;
        int   nm;
        s_ev = !startn && m_pstart;
        p_ev = !stopn  && m_pstop;
        c_ev = !clearn && m_pclear;
        nm   = m_mode;
        if (c_ev)                                  nm = M_IDLE;
        else if (timer_done && m_mode == M_RUN)    nm = M_IDLE;
        else if (!door_closed && m_mode == M_RUN)  nm = M_PAUSE;
        else if (p_ev)                             nm = (m_mode == M_RUN) ? M_PAUSE : M_IDLE;
        else if (s_ev && door_closed && !timer_done && m_mode != M_RUN) nm = M_RUN;
        if (nm == M_RUN && m_mode != M_RUN) begin
            m_t    = 0;
            m_fpwr = clamp_pwr(int'(power_level));
        end else if (m_mode == M_RUN) begin
            m_t++;
            if (m_t % FRAME == 0) m_fpwr = clamp_pwr(int'(power_level));
        end
        m_mode   = nm;
        m_pstart = startn;
        m_pstop  = stopn;
        m_pclear = clearn;
    endtask

    // ---------------- driver tasks ----------------
    // One clock: apply inputs after the falling edge, check, then clock the model.
    task automatic step(input logic s, input logic p, input logic c,
                        input logic d, input logic tm, input logic [PWR_W-1:0] pw);
        startn      = s;
        stopn       = p;
        clearn      = c;
        door_closed = d;
        timer_done  = tm;
        power_level = pw;
        #1;
        check("mag_on",  32'(mag_on),  32'(exp_mag()));
        check("running", 32'(running), 32'(m_mode == M_RUN));
        check("paused",  32'(paused),  32'(m_mode == M_PAUSE));
        obs_mag = mag_on;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle_step(input logic [PWR_W-1:0] pw);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, pw);
    endtask

    task automatic push_pat(input logic [7:0] bits, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(bits[n-1-i]);
    endtask

    // Runs idle-key steps and compares the drive against the queued pattern.
    task automatic run_pattern(input string tag, input int n, input logic [PWR_W-1:0] pw);
        for (int i = 0; i < n; i++) begin
            idle_step(pw);
            if (exp_q.size() == 0) check({tag, "_queue"}, 32'd0, 32'd1);
            else                   check(tag, 32'(obs_mag), 32'(exp_q.pop_front()));
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        resetn      = 1'b0;
        startn      = 1'b1;
        stopn       = 1'b1;
        clearn      = 1'b1;
        door_closed = 1'b1;
        timer_done  = 1'b0;
        power_level = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_mag_on",  32'(mag_on),  32'd0);
        check("rst_running", 32'(running), 32'd0);
        check("rst_paused",  32'(paused),  32'd0);
        resetn = 1'b1;

        // Basic duty: power 2 -> four cycles on, four off.
        idle_step(3'd2);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd2);
        push_pat(8'b1111_0000, 8);
        push_pat(8'b1111_0000, 8);
        run_pattern("duty2", 16, 3'd2);

        // Async reset mid-RUN: outputs drop before the next clock edge.
        idle_step(3'd2);
        resetn = 1'b0;
        #1;
        check("arst_mag_on",  32'(mag_on),  32'd0);
        check("arst_running", 32'(running), 32'd0);
        check("arst_paused",  32'(paused),  32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        repeat (3) idle_step(3'd2);
        check("after_rst_idle", 32'(running), 32'd0);

        // Door opens in slot 0, then close and restart.
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd2);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2);
        check("door_drop", 32'(obs_mag), 32'd0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd2);
        check("door_pause", 32'(paused), 32'd1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd2);
        push_pat(8'b1111_0000, 8);
        run_pattern("door_restart", 8, 3'd2);

        // Stop twice: RUN -> PAUSE -> IDLE; then start+clear together in PAUSE.
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd2);
        idle_step(3'd2);
        check("stop1_pause", 32'(paused), 32'd1);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd2);
        idle_step(3'd2);
        check("stop2_idle", 32'({running, paused}), 32'd0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd2);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd2);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd2);
        idle_step(3'd2);
        check("clear_wins", 32'({running, paused}), 32'd0);

        // Clamp 7 -> full power, then drop to 1 mid-frame.
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd7);
        push_pat(8'b1111_1111, 8);
        push_pat(8'b1111_1111, 2);
        run_pattern("clamp7", 10, 3'd7);
        push_pat(8'b1111_1111, 6);
        push_pat(8'b1100_0000, 8);
        run_pattern("pwr_change", 14, 3'd1);

        // Power 0: running without drive.
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
        push_pat(8'b0000_0000, 8);
        run_pattern("pwr0", 8, 3'd0);
        check("pwr0_running", 32'(running), 32'd1);

        // Timer expiry with start held low, then start while timer asserted.
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd2);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd2);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd2);
        check("timer_no_restart", 32'(running), 32'd0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'd2);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd2);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd2);
        check("timer_start_ignored", 32'(running), 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 7)  != 0,
                 $urandom_range(0, 15) != 0,
                 $urandom_range(0, 40) != 0,
                 $urandom_range(0, 19) != 0,
                 $urandom_range(0, 39) == 0,
                 3'($urandom_range(0, 7)));
            if (running && paused) check("excl_states", 32'd1, 32'd0);
        end

        // ---------------- final report ----------------
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
